sata_recfg_responder: RTL and testbench



---
 rtl/sata_recfg_pkg.sv | 31 +++
 rtl/sata_recfg_be_engine.sv | 148 ++++++++++++++
 rtl/sata_recfg_responder.sv | 124 ++++++++++++
 tb/tb_sata_recfg_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_recfg_pkg.sv
// Shared constants and types for the SATA reconfiguration responder:
// register window addresses, CSR bit positions and the back-end engine states.
package sata_recfg_pkg;

    localparam logic [6:0] ADDR_LCH    = 7'h38;
    localparam logic [6:0] ADDR_CSR    = 7'h3A;
    localparam logic [6:0] ADDR_OFFSET = 7'h3B;
    localparam logic [6:0] ADDR_DATA   = 7'h3C;

    localparam int CSR_WR   = 0;
    localparam int CSR_RD   = 1;
    localparam int CSR_BUSY = 8;
    localparam int CSR_ERR  = 9;

    typedef enum logic [1:0] {
        ENG_IDLE    = 2'd0,
        ENG_WR_REQ  = 2'd1,
        ENG_RD_REQ  = 2'd2,
        ENG_RD_WAIT = 2'd3
    } eng_state_t;

    // Builds the CSR read word from the engine's busy and error flags.
    function automatic logic [31:0] csrReadWord(input logic busy, input logic err);
        logic [31:0] word;
        word           = '0;
        word[CSR_BUSY] = busy;
        word[CSR_ERR]  = err;
        return word;
    endfunction

endpackage

// File: rtl/sata_recfg_be_engine.sv
// Back-end access engine: turns one start command into a single 16-bit
// read or write on the DPRIO-like port, bounded by a timeout counter.
module sata_recfg_be_engine
    import sata_recfg_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start_wr,
    input  logic        i_start_rd,
    input  logic        i_lch_ok,
    input  logic [15:0] i_offset,
    input  logic [15:0] i_wdata,
    input  logic        i_be_busy,
    input  logic [15:0] i_be_rdat,
    input  logic        i_be_rvalid,
    output logic        o_busy,
    output logic        o_error,
    output logic        o_rd_done,
    output logic [15:0] o_rd_data,
    output logic [15:0] o_be_addr,
    output logic [15:0] o_be_wdat,
    output logic        o_be_wreq,
    output logic        o_be_rreq
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    eng_state_t  r_state;
    eng_state_t  w_next;
    logic [7:0]  r_count;
    logic        r_error;
    logic [15:0] r_offset;
    logic [15:0] r_wdata;
    logic        w_start;
    logic        w_timeout_reached;
    logic        w_timeout_fire;

    assign w_start           = (r_state == ENG_IDLE) && (i_start_wr || i_start_rd);
    assign w_timeout_reached = (r_count >= TO_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ENG_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A completing handshake always wins over a timeout in the same cycle.
    always_comb begin
        w_next         = r_state;
        w_timeout_fire = 1'b0;
        case (r_state)
            ENG_IDLE: begin
                if (i_lch_ok) begin
                    if (i_start_wr) begin
                        w_next = ENG_WR_REQ;
                    end else if (i_start_rd) begin
                        w_next = ENG_RD_REQ;
                    end
                end
            end
            ENG_WR_REQ: begin
                if (!i_be_busy) begin
                    w_next = ENG_IDLE;
                end else if (w_timeout_reached) begin
                    w_next         = ENG_IDLE;
                    w_timeout_fire = 1'b1;
                end
            end
            ENG_RD_REQ: begin
                if (!i_be_busy) begin
                    w_next = ENG_RD_WAIT;
                end else if (w_timeout_reached) begin
                    w_next         = ENG_IDLE;
                    w_timeout_fire = 1'b1;
                end
            end
            ENG_RD_WAIT: begin
                if (i_be_rvalid) begin
                    w_next = ENG_IDLE;
                end else if (w_timeout_reached) begin
                    w_next         = ENG_IDLE;
                    w_timeout_fire = 1'b1;
                end
            end
            default: begin
                w_next = ENG_IDLE;
            end
        endcase
    end

    always_comb begin
        o_be_wreq = 1'b0;
        o_be_rreq = 1'b0;
        o_busy    = 1'b0;
        o_rd_done = 1'b0;
        case (r_state)
            ENG_WR_REQ: begin
                o_be_wreq = 1'b1;
                o_busy    = 1'b1;
            end
            ENG_RD_REQ: begin
                o_be_rreq = 1'b1;
                o_busy    = 1'b1;
            end
            ENG_RD_WAIT: begin
                o_busy    = 1'b1;
                o_rd_done = i_be_rvalid;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    // A rejected start (wrong channel) only flags the error; the back-end
    // address and data stay where they were.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count  <= 8'd0;
            r_error  <= 1'b0;
            r_offset <= 16'd0;
            r_wdata  <= 16'd0;
        end else if (w_start) begin
            r_count <= 8'd0;
            r_error <= ~i_lch_ok;
            if (i_lch_ok) begin
                r_offset <= i_offset;
                r_wdata  <= i_wdata;
            end
        end else if (r_state != ENG_IDLE) begin
            r_count <= r_count + 8'd1;
            if (w_timeout_fire) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_error   = r_error;
    assign o_be_addr = r_offset;
    assign o_be_wdat = r_wdata;
    assign o_rd_data = i_be_rdat;

endmodule

// File: rtl/sata_recfg_responder.sv
// Avalon-MM-style stand-in for the vendor reconfiguration controller:
// register window, registered two-cycle reads and the back-end engine.
module sata_recfg_responder
    import sata_recfg_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter int TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  recfg_addr,
    input  logic        recfg_wreq,
    input  logic [31:0] recfg_wdat,
    input  logic        recfg_rreq,
    output logic [31:0] recfg_rdat,
    output logic        recfg_busy,
    output logic [15:0] be_addr,
    output logic        be_wreq,
    output logic        be_rreq,
    output logic [15:0] be_wdat,
    input  logic        be_busy,
    input  logic [15:0] be_rdat,
    input  logic        be_rvalid
);

    logic [9:0]  r_lch;
    logic [15:0] r_offset;
    logic [31:0] r_data;
    logic        r_rd_phase;
    logic [31:0] r_rdat;

    logic        w_eng_busy;
    logic        w_eng_error;
    logic        w_rd_done;
    logic [15:0] w_rd_data;
    logic        w_reg_wr;
    logic        w_csr_wr;
    logic        w_start_wr;
    logic        w_start_rd;
    logic        w_lch_ok;
    logic        w_rd_accept;
    logic [31:0] w_rd_mux;

    // Register writes are locked out while the engine owns OFFSET/DATA.
    assign w_reg_wr    = recfg_wreq && !w_eng_busy;
    assign w_csr_wr    = w_reg_wr && (recfg_addr == ADDR_CSR);
    assign w_start_wr  = w_csr_wr && recfg_wdat[CSR_WR];
    assign w_start_rd  = w_csr_wr && recfg_wdat[CSR_RD] && !recfg_wdat[CSR_WR];
    assign w_lch_ok    = (r_lch == 10'(CHANNEL));
    assign w_rd_accept = recfg_rreq && !r_rd_phase;

    sata_recfg_be_engine #(
        .TIMEOUT (TIMEOUT)
    ) u_engine (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start_wr  (w_start_wr),
        .i_start_rd  (w_start_rd),
        .i_lch_ok    (w_lch_ok),
        .i_offset    (r_offset),
        .i_wdata     (r_data[15:0]),
        .i_be_busy   (be_busy),
        .i_be_rdat   (be_rdat),
        .i_be_rvalid (be_rvalid),
        .o_busy      (w_eng_busy),
        .o_error     (w_eng_error),
        .o_rd_done   (w_rd_done),
        .o_rd_data   (w_rd_data),
        .o_be_addr   (be_addr),
        .o_be_wdat   (be_wdat),
        .o_be_wreq   (be_wreq),
        .o_be_rreq   (be_rreq)
    );

    // DATA completion only happens while busy, so it never races a host write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lch    <= 10'd0;
            r_offset <= 16'd0;
            r_data   <= 32'd0;
        end else begin
            if (w_reg_wr) begin
                case (recfg_addr)
                    ADDR_LCH:    r_lch    <= recfg_wdat[9:0];
                    ADDR_OFFSET: r_offset <= recfg_wdat[15:0];
                    ADDR_DATA:   r_data   <= recfg_wdat;
                    default:     r_lch    <= r_lch;
                endcase
            end
            if (w_rd_done) begin
                r_data <= {16'h0000, w_rd_data};
            end
        end
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (recfg_addr)
            ADDR_LCH:    w_rd_mux = {22'd0, r_lch};
            ADDR_CSR:    w_rd_mux = csrReadWord(w_eng_busy, w_eng_error);
            ADDR_OFFSET: w_rd_mux = {16'd0, r_offset};
            ADDR_DATA:   w_rd_mux = r_data;
            default:     w_rd_mux = 32'd0;
        endcase
    end

    // First read cycle captures the mux; the second presents it with busy low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_phase <= 1'b0;
            r_rdat     <= 32'd0;
        end else begin
            r_rd_phase <= w_rd_accept;
            if (w_rd_accept) begin
                r_rdat <= w_rd_mux;
            end
        end
    end

    assign recfg_rdat = r_rdat;
    assign recfg_busy = w_rd_accept;

endmodule

// File: tb/tb_sata_recfg_responder.sv
// Directed self-checking bench for sata_recfg_responder with hand-computed
// expected values for writes, reads, channel errors, timeout and reset.
module tb_sata_recfg_responder;

    logic        clk;
    logic        reset;
    logic [6:0]  recfg_addr;
    logic        recfg_wreq;
    logic [31:0] recfg_wdat;
    logic        recfg_rreq;
    logic [31:0] recfg_rdat;
    logic        recfg_busy;
    logic [15:0] be_addr;
    logic        be_wreq;
    logic        be_rreq;
    logic [15:0] be_wdat;
    logic        be_busy;
    logic [15:0] be_rdat;
    logic        be_rvalid;

    int          testCount;
    int          failCount;
    logic [31:0] rd;

    sata_recfg_responder #(
        .CHANNEL (0),
        .TIMEOUT (255)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .recfg_addr (recfg_addr),
        .recfg_wreq (recfg_wreq),
        .recfg_wdat (recfg_wdat),
        .recfg_rreq (recfg_rreq),
        .recfg_rdat (recfg_rdat),
        .recfg_busy (recfg_busy),
        .be_addr    (be_addr),
        .be_wreq    (be_wreq),
        .be_rreq    (be_rreq),
        .be_wdat    (be_wdat),
        .be_busy    (be_busy),
        .be_rdat    (be_rdat),
        .be_rvalid  (be_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        recfg_wreq = 1'b1;
        recfg_addr = a;
        recfg_wdat = d;
        @(posedge clk);
        #1;
        recfg_wreq = 1'b0;
        recfg_wdat = 32'd0;
    endtask

    task automatic busRead(input logic [6:0] a, output logic [31:0] d);
        int waits;
        waits = 0;
        @(posedge clk);
        #1;
        recfg_rreq = 1'b1;
        recfg_addr = a;
        #1;
        checkOutput("rdBusyFirst", {31'd0, recfg_busy}, 32'd1);
        while (recfg_busy && waits < 8) begin
            @(posedge clk);
            #1;
            waits++;
        end
        checkOutput("rdWaitCycles", waits, 32'd1);
        d = recfg_rdat;
        recfg_rreq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testCount  = 0;
        failCount  = 0;
        reset      = 1'b1;
        recfg_addr = 7'd0;
        recfg_wreq = 1'b0;
        recfg_wdat = 32'd0;
        recfg_rreq = 1'b0;
        be_busy    = 1'b0;
        be_rdat    = 16'd0;
        be_rvalid  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstRdat", recfg_rdat, 32'd0);
        checkOutput("rstBusy", {31'd0, recfg_busy}, 32'd0);
        checkOutput("rstBeWreq", {31'd0, be_wreq}, 32'd0);
        checkOutput("rstBeRreq", {31'd0, be_rreq}, 32'd0);
        checkOutput("rstBeAddr", {16'd0, be_addr}, 32'd0);
        checkOutput("rstBeWdat", {16'd0, be_wdat}, 32'd0);
        reset = 1'b0;
        busRead(7'h38, rd); checkOutput("rstLch", rd, 32'd0);
        busRead(7'h3A, rd); checkOutput("rstCsr", rd, 32'd0);
        busRead(7'h3C, rd); checkOutput("rstData", rd, 32'd0);

        // Simple back-end write
        applyStimulus(7'h3B, 32'h0000_0012);
        applyStimulus(7'h3C, 32'h0000_ABCD);
        applyStimulus(7'h3A, 32'h0000_0001);
        checkOutput("wrReq", {31'd0, be_wreq}, 32'd1);
        checkOutput("wrAddr", {16'd0, be_addr}, 32'h0012);
        checkOutput("wrWdat", {16'd0, be_wdat}, 32'hABCD);
        checkOutput("wrNoRreq", {31'd0, be_rreq}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("wrReqDrop", {31'd0, be_wreq}, 32'd0);
        busRead(7'h3A, rd); checkOutput("wrCsrDone", rd, 32'h000);
        busRead(7'h3B, rd); checkOutput("wrOffsetRb", rd, 32'h0012);
        busRead(7'h40, rd); checkOutput("unmappedRd", rd, 32'd0);

        // Back-end read with delayed rvalid
        applyStimulus(7'h3B, 32'h0000_0020);
        applyStimulus(7'h3A, 32'h0000_0002);
        checkOutput("rdReq", {31'd0, be_rreq}, 32'd1);
        checkOutput("rdAddr", {16'd0, be_addr}, 32'h0020);
        busRead(7'h3A, rd); checkOutput("rdCsrBusy", rd, 32'h100);
        checkOutput("rdReqDropped", {31'd0, be_rreq}, 32'd0);
        @(posedge clk);
        #1;
        be_rvalid = 1'b1;
        be_rdat   = 16'h5A5A;
        @(posedge clk);
        #1;
        be_rvalid = 1'b0;
        be_rdat   = 16'h0000;
        busRead(7'h3C, rd); checkOutput("rdData", rd, 32'h0000_5A5A);
        busRead(7'h3A, rd); checkOutput("rdCsrDone", rd, 32'h000);

        // Stray rvalid while idle must not touch DATA
        @(posedge clk);
        #1;
        be_rvalid = 1'b1;
        be_rdat   = 16'h1111;
        @(posedge clk);
        #1;
        be_rvalid = 1'b0;
        be_rdat   = 16'h0000;
        busRead(7'h3C, rd); checkOutput("strayRvalid", rd, 32'h0000_5A5A);

        // Wrong logical channel
        applyStimulus(7'h38, 32'h0000_0001);
        applyStimulus(7'h3A, 32'h0000_0002);
        checkOutput("lchNoRreq", {31'd0, be_rreq}, 32'd0);
        busRead(7'h3A, rd); checkOutput("lchCsrErr", rd, 32'h200);
        busRead(7'h38, rd); checkOutput("lchRb", rd, 32'h001);
        applyStimulus(7'h38, 32'h0000_0000);

        // Read timeout: rvalid never arrives
        applyStimulus(7'h3A, 32'h0000_0002);
        checkOutput("toRreq", {31'd0, be_rreq}, 32'd1);
        busRead(7'h3A, rd); checkOutput("toStartClrErr", rd, 32'h100);
        repeat (238) @(posedge clk);
        busRead(7'h3A, rd); checkOutput("toStillBusy", rd, 32'h100);
        repeat (20) @(posedge clk);
        busRead(7'h3A, rd); checkOutput("toCsrErr", rd, 32'h200);
        checkOutput("toNoRreq", {31'd0, be_rreq}, 32'd0);
        busRead(7'h3C, rd); checkOutput("toDataKept", rd, 32'h0000_5A5A);

        // Next good operation clears the error
        applyStimulus(7'h3A, 32'h0000_0001);
        checkOutput("recWreq", {31'd0, be_wreq}, 32'd1);
        checkOutput("recWdat", {16'd0, be_wdat}, 32'h5A5A);
        busRead(7'h3A, rd); checkOutput("recCsrClr", rd, 32'h000);

        // Both start bits: write wins; writes while busy are ignored
        applyStimulus(7'h3C, 32'h0000_1234);
        applyStimulus(7'h3B, 32'h0000_0040);
        be_busy = 1'b1;
        applyStimulus(7'h3A, 32'h0000_0003);
        checkOutput("bothWreq", {31'd0, be_wreq}, 32'd1);
        checkOutput("bothNoRreq", {31'd0, be_rreq}, 32'd0);
        applyStimulus(7'h3C, 32'h0000_FFFF);
        applyStimulus(7'h3A, 32'h0000_0002);
        applyStimulus(7'h3B, 32'h0000_0099);
        checkOutput("busyWreqHeld", {31'd0, be_wreq}, 32'd1);
        checkOutput("busyWdatHeld", {16'd0, be_wdat}, 32'h1234);
        checkOutput("busyAddrHeld", {16'd0, be_addr}, 32'h0040);
        be_busy = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("bothWreqDrop", {31'd0, be_wreq}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("bothNoLateRreq", {31'd0, be_rreq}, 32'd0);
        busRead(7'h3C, rd); checkOutput("busyDataKept", rd, 32'h0000_1234);
        busRead(7'h3B, rd); checkOutput("busyOffsetKept", rd, 32'h0040);
        busRead(7'h3A, rd); checkOutput("busyCsrClean", rd, 32'h000);

        // Reset during RD_WAIT
        applyStimulus(7'h3A, 32'h0000_0002);
        recfg_rreq = 1'b1;
        recfg_addr = 7'h3C;
        @(posedge clk);
        #1;
        checkOutput("preRstRdat", recfg_rdat, 32'h0000_1234);
        checkOutput("preRstWait", {31'd0, be_rreq}, 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("midRstRreq", {31'd0, be_rreq}, 32'd0);
        checkOutput("midRstRdat", recfg_rdat, 32'd0);
        checkOutput("midRstAddr", {16'd0, be_addr}, 32'd0);
        checkOutput("midRstWdat", {16'd0, be_wdat}, 32'd0);
        recfg_rreq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        be_rvalid = 1'b1;
        be_rdat   = 16'hBEEF;
        @(posedge clk);
        #1;
        be_rvalid = 1'b0;
        be_rdat   = 16'h0000;
        busRead(7'h3C, rd); checkOutput("postRstData", rd, 32'd0);
        busRead(7'h3B, rd); checkOutput("postRstOffset", rd, 32'd0);
        busRead(7'h3A, rd); checkOutput("postRstCsr", rd, 32'd0);
        busRead(7'h38, rd); checkOutput("postRstLch", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
